// File: rtl/sha3_pkg.sv
// Shared constants and FSM encoding for the SHA-3 front-end (padding) stage.
package sha3_pkg;
    localparam int STATE_SIZE = 1600;
    localparam int Z_WIDTH    = 64;

    localparam logic [7:0] PAD_FIRST = 8'h06;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    typedef enum logic [1:0] {COLLECT, SEND, SEND_PAD_ONLY} pad_state_t;
endpackage

// File: rtl/sha3_pad_mask.sv
// Combinational pad10*1 helper: byte-keep mask for the final word and the
// block-wide XOR pattern that places the domain suffix and the closing 0x80.
module sha3_pad_mask
    import sha3_pkg::*;
#(
    parameter int R_BLOCK_SIZE = 1152,
    parameter int W_WIDTH      = 64,
    parameter int CW           = 5
) (
    input  logic [CW-1:0]           wcnt,
    input  logic [3:0]              nbytes,
    output logic [W_WIDTH-1:0]      keep,
    output logic [R_BLOCK_SIZE-1:0] pad,
    output logic                    full
);
    localparam int WB = W_WIDTH / 8;
    localparam int NB = R_BLOCK_SIZE / 8;

    // Byte 0 sits on the MSB side, so ascending packed ranges map directly.
    logic [0:WB-1][7:0] keep_b;
    logic [0:NB-1][7:0] pad_b;
    int                 p;

    always_comb begin
        keep_b = '0;
        pad_b  = '0;
        p      = int'(wcnt) * WB + int'(nbytes);
        full   = (p == NB);
        for (int j = 0; j < WB; j++)
            if (j < int'(nbytes)) keep_b[j] = 8'hFF;
        if (p < NB) begin
            for (int k = 0; k < NB; k++)
                if (k == p) pad_b[k] = PAD_FIRST;
            pad_b[NB-1] = pad_b[NB-1] | PAD_LAST;
        end
    end

    assign keep = keep_b;
    assign pad  = pad_b;
endmodule

// File: rtl/sha3_padding_unit.sv
// Assembles 64-bit message words into rate blocks, applies SHA-3 padding to the
// final block and hands each block to the permutation with a one-cycle strobe.
module sha3_padding_unit
    import sha3_pkg::*;
#(
    parameter int R_BLOCK_SIZE = 1152,
    parameter int W_WIDTH      = 64
) (
    input  logic                    CLK,
    input  logic                    A_RST,
    input  logic                    CE,
    input  logic [W_WIDTH-1:0]      DATA_IN,
    input  logic                    DATA_VALID,
    input  logic                    DATA_LAST,
    input  logic [3:0]              DATA_BYTES,
    output logic                    DATA_READY,
    input  logic                    PERM_READY,
    output logic [R_BLOCK_SIZE-1:0] BLOCK_OUT,
    output logic                    VALID_MESSAGE,
    output logic                    LAST_MESSAGE
);
    localparam int NW = R_BLOCK_SIZE / W_WIDTH;
    localparam int CW = $clog2(NW);
    localparam logic [CW-1:0] WLAST = CW'(NW - 1);
    localparam logic [3:0]    MAX_B = 4'(W_WIDTH / 8);
    localparam logic [R_BLOCK_SIZE-1:0] PAD_ONLY =
        {PAD_FIRST, {(R_BLOCK_SIZE-16){1'b0}}, PAD_LAST};

    pad_state_t                 state;
    logic [CW-1:0]              wcnt;
    logic [0:NW-1][W_WIDTH-1:0] blk, blk_wr;
    logic                       last_flag, pad_pending;
    logic [W_WIDTH-1:0]         keep, word;
    logic [R_BLOCK_SIZE-1:0]    pad;
    logic                       full, accept, fire;

    sha3_pad_mask #(.R_BLOCK_SIZE(R_BLOCK_SIZE), .W_WIDTH(W_WIDTH), .CW(CW)) u_mask (
        .wcnt   (wcnt),
        .nbytes (DATA_BYTES),
        .keep   (keep),
        .pad    (pad),
        .full   (full)
    );

    assign DATA_READY    = CE && !A_RST && (state == COLLECT);
    assign accept        = DATA_VALID && DATA_READY;
    assign fire          = CE && PERM_READY && (state != COLLECT);
    assign VALID_MESSAGE = fire;
    assign LAST_MESSAGE  = fire && ((state == SEND_PAD_ONLY) || last_flag);
    assign BLOCK_OUT     = blk;

    always_comb begin
        word         = DATA_LAST ? (DATA_IN & keep) : DATA_IN;
        blk_wr       = blk;
        blk_wr[wcnt] = word;
    end

    always_ff @(posedge CLK or posedge A_RST) begin
        if (A_RST) begin
            state       <= COLLECT;
            wcnt        <= '0;
            blk         <= '0;
            last_flag   <= 1'b0;
            pad_pending <= 1'b0;
        end else if (CE) begin
            case (state)
                COLLECT: if (accept) begin
                    if (DATA_LAST) begin
                        // An exactly-full final block leaves padding for a block of its own.
                        blk         <= blk_wr ^ pad;
                        wcnt        <= '0;
                        state       <= SEND;
                        last_flag   <= !full;
                        pad_pending <= full;
                    end else begin
                        blk <= blk_wr;
                        if (wcnt == WLAST) begin
                            wcnt      <= '0;
                            state     <= SEND;
                            last_flag <= 1'b0;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                SEND: if (PERM_READY) begin
                    if (pad_pending) begin
                        state       <= SEND_PAD_ONLY;
                        blk         <= PAD_ONLY;
                        pad_pending <= 1'b0;
                    end else begin
                        state <= COLLECT;
                        blk   <= '0;
                    end
                end
                SEND_PAD_ONLY: if (PERM_READY) begin
                    state <= COLLECT;
                    blk   <= '0;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!A_RST && accept && DATA_LAST)
            assert (DATA_BYTES <= MAX_B)
            else $error("DATA_BYTES %0d exceeds word size", DATA_BYTES);
    end
endmodule

// File: tb/tb_sha3_padding_unit.sv
// Directed bench for sha3_padding_unit: empty, "abc", 143/144-byte messages,
// permutation back-pressure, mid-message reset and clock-enable gaps.
module tb_sha3_padding_unit;
    localparam int R  = 1152;
    localparam int W  = 64;
    localparam int NB = R / 8;

    localparam logic [R-1:0] PAD_BLK = {8'h06, {(R-16){1'b0}}, 8'h80};
    localparam logic [R-1:0] ABC_BLK = {24'h616263, 8'h06, {(R-40){1'b0}}, 8'h80};

    logic         CLK = 1'b0;
    logic         A_RST, CE, DATA_VALID, DATA_LAST, PERM_READY;
    logic [W-1:0] DATA_IN;
    logic [3:0]   DATA_BYTES;
    logic         DATA_READY, VALID_MESSAGE, LAST_MESSAGE;
    logic [R-1:0] BLOCK_OUT;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] msg [NB];

    sha3_padding_unit #(.R_BLOCK_SIZE(R), .W_WIDTH(W)) dut (
        .CLK           (CLK),
        .A_RST         (A_RST),
        .CE            (CE),
        .DATA_IN       (DATA_IN),
        .DATA_VALID    (DATA_VALID),
        .DATA_LAST     (DATA_LAST),
        .DATA_BYTES    (DATA_BYTES),
        .DATA_READY    (DATA_READY),
        .PERM_READY    (PERM_READY),
        .BLOCK_OUT     (BLOCK_OUT),
        .VALID_MESSAGE (VALID_MESSAGE),
        .LAST_MESSAGE  (LAST_MESSAGE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [R-1:0] obs, input logic [R-1:0] exp);
        logic [R-1:0] so, se;
        int           k;
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            k = 0;
            so = obs;
            se = exp;
            while (k < NB - 1 && so[R-1 -: 8] === se[R-1 -: 8]) begin
                so = so << 8;
                se = se << 8;
                k++;
            end
            $error("FAIL %s first bad byte %0d observed %h expected %h", tag, k,
                   so[R-1 -: 8], se[R-1 -: 8]);
        end
    endtask

    function automatic logic [R-1:0] exp_block(input int len);
        logic [R-1:0] e = '0;
        for (int k = 0; k < len && k < NB; k++)
            e = e | ({msg[k], {(R-8){1'b0}}} >> (8 * k));
        if (len < NB) begin
            e = e | ({8'h06, {(R-8){1'b0}}} >> (8 * len));
            e[7:0] = e[7:0] ^ 8'h80;
        end
        return e;
    endfunction

    task automatic send_word(input logic [W-1:0] d, input logic last, input logic [3:0] b);
        int n = 0;
        @(negedge CLK);
        DATA_IN = d; DATA_VALID = 1'b1; DATA_LAST = last; DATA_BYTES = b;
        #1;
        while (!DATA_READY && n < 50) begin
            @(negedge CLK); #1; n++;
        end
        chk("accept", 32'(DATA_READY), 32'd1);
        @(posedge CLK); #1;
        DATA_VALID = 1'b0; DATA_LAST = 1'b0;
    endtask

    task automatic run_msg(input int len);
        int nw = (len == 0) ? 1 : (len + 7) / 8;
        for (int i = 0; i < nw; i++) begin
            logic [W-1:0] d = '0;
            logic         last = (i == nw - 1);
            int           b = last ? len - 8 * i : 0;
            for (int j = 0; j < 8; j++) begin
                int idx = 8 * i + j;
                d = {d[W-9:0], (idx < len) ? msg[idx] : 8'hEE};
            end
            send_word(d, last, 4'(b));
        end
    endtask

    task automatic wait_block(input string tag, input logic [R-1:0] exp, input logic exp_last);
        int n = 0;
        @(negedge CLK); #1;
        while (!VALID_MESSAGE && n < 50) begin
            @(negedge CLK); #1; n++;
        end
        chk({tag, "_latency"}, n, 0);
        chk({tag, "_valid"}, 32'(VALID_MESSAGE), 32'd1);
        chk({tag, "_last"}, 32'(LAST_MESSAGE), 32'(exp_last));
        chk_blk({tag, "_block"}, BLOCK_OUT, exp);
        @(posedge CLK); #1;
    endtask

    task automatic idle_chk(input string tag);
        @(negedge CLK); #1;
        chk({tag, "_no_strobe"}, 32'(VALID_MESSAGE), 32'd0);
        chk({tag, "_ready"}, 32'(DATA_READY), 32'd1);
    endtask

    initial begin
        A_RST = 1'b1; CE = 1'b1; PERM_READY = 1'b1;
        DATA_IN = '0; DATA_VALID = 1'b0; DATA_LAST = 1'b0; DATA_BYTES = '0;
        for (int k = 0; k < NB; k++) msg[k] = 8'h00;

        repeat (2) @(negedge CLK);
        #1;
        chk("rst_ready", 32'(DATA_READY), 32'd0);
        chk("rst_valid", 32'(VALID_MESSAGE), 32'd0);
        chk("rst_last", 32'(LAST_MESSAGE), 32'd0);
        chk_blk("rst_block", BLOCK_OUT, '0);
        @(negedge CLK); A_RST = 1'b0; #1;
        chk("post_rst_ready", 32'(DATA_READY), 32'd1);

        // Empty message: a lone padding block.
        run_msg(0);
        wait_block("empty", PAD_BLK, 1'b1);
        idle_chk("empty");

        // "abc" with garbage in the unused bytes of the word.
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_msg(3);
        wait_block("abc", ABC_BLK, 1'b1);
        idle_chk("abc");

        // 143 bytes: suffix and closing bit share the last byte (0x86).
        for (int k = 0; k < NB; k++) msg[k] = 8'((k * 37 + 11) & 8'hFF);
        run_msg(143);
        wait_block("len143", exp_block(143), 1'b1);
        idle_chk("len143");

        // 144 bytes: full data block, then a pad-only block.
        run_msg(144);
        wait_block("len144_data", exp_block(144), 1'b0);
        wait_block("len144_pad", PAD_BLK, 1'b1);
        idle_chk("len144");

        // Permutation busy for 10 cycles: block held, no strobe.
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        PERM_READY = 1'b0;
        run_msg(3);
        repeat (10) begin
            @(negedge CLK); #1;
            chk("stall_valid", 32'(VALID_MESSAGE), 32'd0);
            chk("stall_ready", 32'(DATA_READY), 32'd0);
            chk_blk("stall_block", BLOCK_OUT, ABC_BLK);
        end
        PERM_READY = 1'b1; #1;
        chk("stall_release_valid", 32'(VALID_MESSAGE), 32'd1);
        chk("stall_release_last", 32'(LAST_MESSAGE), 32'd1);
        chk_blk("stall_release_block", BLOCK_OUT, ABC_BLK);
        @(posedge CLK); #1;
        idle_chk("stall");

        // Five words of a message, then reset: nothing may leak into "abc".
        for (int i = 0; i < 5; i++) send_word({8{8'(8'hA0 + i)}}, 1'b0, 4'd0);
        @(negedge CLK); A_RST = 1'b1; #1;
        chk("midrst_ready", 32'(DATA_READY), 32'd0);
        @(negedge CLK); A_RST = 1'b0;

        // CE low while a word is offered: no acceptance.
        CE = 1'b0; DATA_IN = 64'h616263EEEEEEEEEE; DATA_VALID = 1'b1;
        DATA_LAST = 1'b1; DATA_BYTES = 4'd3;
        repeat (3) begin
            @(negedge CLK); #1;
            chk("ce_off_ready", 32'(DATA_READY), 32'd0);
        end
        CE = 1'b1;
        run_msg(3);

        // CE low while the block waits: no strobe until CE returns.
        @(negedge CLK); CE = 1'b0;
        repeat (3) begin
            #1;
            chk("ce_off_valid", 32'(VALID_MESSAGE), 32'd0);
            chk_blk("ce_off_block", BLOCK_OUT, ABC_BLK);
            @(negedge CLK);
        end
        CE = 1'b1; #1;
        chk("rst_abc_valid", 32'(VALID_MESSAGE), 32'd1);
        chk("rst_abc_last", 32'(LAST_MESSAGE), 32'd1);
        chk_blk("rst_abc_block", BLOCK_OUT, ABC_BLK);
        @(posedge CLK); #1;
        idle_chk("rst_abc");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha3_padding_unit.md
Name: sha3_padding_unit

Overview:
- Upstream stage of the SHA-3 permutation datapath.
- Accepts the message as a stream of 64-bit words and assembles R_BLOCK_SIZE-bit rate blocks.
- Applies SHA-3 pad10*1 with domain suffix 0x06 to the final block.
- Presents each block with a one-cycle valid strobe and a last-block flag to the permutation stage; holds the block until the permutation is ready.

Parameters:
R_BLOCK_SIZE, 1152, rate in bits; multiple of W_WIDTH (1152/1088/832/576 for SHA3-224/256/384/512)
W_WIDTH, 64, input word width in bits; multiple of 8

Ports:
CLK  in  1  clock
A_RST  in  1  asynchronous reset, active-high
CE  in  1  clock enable; all state updates are gated by CE
DATA_IN  in  W_WIDTH  message word; byte j = DATA_IN[8j:8j+7], index 0 = MSB side
DATA_VALID  in  1  DATA_IN valid
DATA_LAST  in  1  final message word
DATA_BYTES  in  4  valid bytes in the final word, 0..W_WIDTH/8 (0 = no message bytes); ignored unless DATA_LAST
DATA_READY  out  1  word accepted when DATA_VALID & DATA_READY & CE
PERM_READY  in  1  permutation idle and waiting for a new block
BLOCK_OUT  out  R_BLOCK_SIZE  rate block; message byte k of the block = BLOCK_OUT[8k:8k+7]
VALID_MESSAGE  out  1  one-cycle strobe: BLOCK_OUT valid, permutation absorbs it
LAST_MESSAGE  out  1  qualifies VALID_MESSAGE: final block of the message

Behaviour:
- Reset values:
  - FSM = COLLECT; word counter = 0; block buffer = all 0.
  - DATA_READY = 0 during reset, then 1 in COLLECT.
  - VALID_MESSAGE = 0; LAST_MESSAGE = 0; BLOCK_OUT = 0.
- Constants: NW = R_BLOCK_SIZE/W_WIDTH; NB = R_BLOCK_SIZE/8; word counter is $clog2(NW) bits.
- FSM states: COLLECT, SEND, SEND_PAD_ONLY.
- COLLECT:
  - DATA_READY = 1.
  - An accepted word is written to buffer word slot wcnt.
  - Non-last word:
    - wcnt < NW-1: wcnt++.
    - wcnt == NW-1: go to SEND with last_flag = 0; wcnt wraps to 0.
  - Last word with b = DATA_BYTES:
    - Bytes b..W_WIDTH/8-1 of the word are forced to 0.
    - p = wcnt*W_WIDTH/8 + b.
    - If p < NB: byte p ^= 0x06, byte NB-1 ^= 0x80 (0x86 when p == NB-1); go to SEND with last_flag = 1.
    - If p == NB (block exactly full): go to SEND with last_flag = 0 and set pad_pending.
  - Slots after the last word are already 0 (buffer is cleared after every send).
- SEND:
  - DATA_READY = 0.
  - When PERM_READY & CE: VALID_MESSAGE = 1 and LAST_MESSAGE = last_flag for exactly that cycle; BLOCK_OUT = buffer.
  - Next state:
    - pad_pending: SEND_PAD_ONLY; buffer := 0x06 at byte 0, 0x80 at byte NB-1; pad_pending cleared.
    - Otherwise: COLLECT; buffer := 0.
  - While PERM_READY = 0 the block is held and no strobe is issued.
- SEND_PAD_ONLY: same as SEND with LAST_MESSAGE = 1; then COLLECT, buffer := 0.
- Latency: a block is presented 1 cycle after the word completing it is accepted (earliest); VALID_MESSAGE is combinational from state & PERM_READY & CE.
- BLOCK_OUT is only meaningful while VALID_MESSAGE = 1; it is driven from the buffer at all times.
- CE = 0: no state change, no handshakes; VALID_MESSAGE = 0, DATA_READY = 0.
- Back-to-back messages: the first word of message N+1 may be accepted the cycle after LAST of message N is sent.
- A_RST mid-operation: partial block, pad_pending and counter are discarded; the next accepted word starts a new message.
- DATA_BYTES > W_WIDTH/8 on a last word: undefined; flagged by an assertion.

Decomposition:
- Package sha3_pkg:
  - STATE_SIZE = 1600, Z_WIDTH = 64.
  - PAD_FIRST = 8'h06, PAD_LAST = 8'h80.
  - Enum pad_state_t {COLLECT, SEND, SEND_PAD_ONLY}.
- Sub-module sha3_pad_mask (combinational): given wcnt and DATA_BYTES, produces the byte-keep mask and the pad XOR pattern for the block. The top level holds the FSM, counter and buffer.

Test Plan:
- Empty message (DATA_LAST, DATA_BYTES = 0, wcnt = 0) -> one block: byte 0 = 0x06, byte 143 = 0x80, all others 0; LAST_MESSAGE = 1.
- 3-byte message "abc" (DATA_IN = 0x616263xx..., bytes = 3) -> bytes 0..2 = 61 62 63, byte 3 = 0x06, byte 143 = 0x80, rest 0, single strobe.
- 143-byte message (17 full words + 7 bytes) -> byte 143 = 0x86, one block, LAST = 1.
- 144-byte message (18 full words, last bytes = 8) -> data block with LAST = 0, then pad-only block 0x06 at byte 0 / 0x80 at byte 143 with LAST = 1.
- PERM_READY held 0 for 10 cycles in SEND -> no strobe, DATA_READY = 0, block stable; strobe on the first cycle PERM_READY = 1.
- A_RST asserted after 5 words, then "abc" -> output identical to the "abc" scenario with no residue from the 5 words; CE = 0 cycles inserted cause no state change.
